// File: rtl/matrix_txctrl_pkg.sv
// Shared definitions for the TX frame sequencer: state encoding, word and
// length widths, and the chunk-size helper.
package matrix_txctrl_pkg;

  localparam int unsigned TXCTRL_WORD_BITS = 32;
  localparam int unsigned TXCTRL_LEN_W     = 16;
  localparam int unsigned TXCTRL_CNT_W     = 8;

  // One-hot sequencer states.
  typedef enum logic [4:0] {
    TXCTRL_IDLE  = 5'b00001,
    TXCTRL_FETCH = 5'b00010,
    TXCTRL_LOAD  = 5'b00100,
    TXCTRL_SHIFT = 5'b01000,
    TXCTRL_DONE  = 5'b10000
  } txCtrlState_e;

  // Bits carried by the next word: min(remaining, word size).
  function automatic logic [TXCTRL_CNT_W-1:0] chunkBits(input logic [31:0] remBits);
    if (remBits >= TXCTRL_WORD_BITS)
      return TXCTRL_CNT_W'(TXCTRL_WORD_BITS);
    else
      return remBits[TXCTRL_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/matrix_txctrl_if.sv
// Frame command, TX FIFO and shift-register control bundle of the sequencer.
interface matrix_txctrl_if #(
  parameter int unsigned LEN_W = matrix_txctrl_pkg::TXCTRL_LEN_W
);
  logic             tx_FrameStart;
  logic [LEN_W-1:0] tx_FrameBitLen;
  logic             tx_Abort;
  logic [31:0]      TxFifoData;
  logic             TxFifoEmpty;
  logic             TxFifoRd;
  logic [31:0]      tx_ShiftDataIn;
  logic [7:0]       tx_ShiftBitCnt;
  logic             tx_ShiftLoad;
  logic             tx_ShiftStart;
  logic             tx_FinalShiftLoadErase;
  logic             tx_ShiftEmpty;
  logic             tx_Busy;
  logic             tx_FrameDone;
  logic             tx_Underrun;

  // Sequencer side.
  modport master (
    input  tx_FrameStart, tx_FrameBitLen, tx_Abort,
    input  TxFifoData, TxFifoEmpty, tx_ShiftEmpty,
    output TxFifoRd, tx_ShiftDataIn, tx_ShiftBitCnt, tx_ShiftLoad,
    output tx_ShiftStart, tx_FinalShiftLoadErase,
    output tx_Busy, tx_FrameDone, tx_Underrun
  );

  // Host / FIFO / shift-register side.
  modport slave (
    output tx_FrameStart, tx_FrameBitLen, tx_Abort,
    output TxFifoData, TxFifoEmpty, tx_ShiftEmpty,
    input  TxFifoRd, tx_ShiftDataIn, tx_ShiftBitCnt, tx_ShiftLoad,
    input  tx_ShiftStart, tx_FinalShiftLoadErase,
    input  tx_Busy, tx_FrameDone, tx_Underrun
  );
endinterface

// File: rtl/matrix_txctrl.sv
// TX frame sequencer: pulls words from the FWFT TX FIFO and drives the
// load/start/erase controls of the shift register, with one prefetch word
// so consecutive words go out without a gap.
module matrix_txctrl
  import matrix_txctrl_pkg::*;
#(
  parameter int unsigned LEN_W = TXCTRL_LEN_W
) (
  input logic          Clk,
  input logic          Reset,
  matrix_txctrl_if.master bus
);

  txCtrlState_e                state;
  logic [LEN_W-1:0]            remBits;
  logic [TXCTRL_WORD_BITS-1:0] hold;
  logic [TXCTRL_CNT_W-1:0]     holdCnt;
  logic [TXCTRL_CNT_W-1:0]     chunk;
  logic                        holdValid;
  logic                        lastChunk;
  logic                        fifoRd;
  logic                        loadReg;
  logic                        shiftStart;
  logic                        busy;
  logic                        frameDone;
  logic                        underrun;
  logic                        inShift;
  logic                        reloadNow;
  logic                        underrunNow;
  logic                        finalErase;
  logic                        prefetch;

  // Chunk size of the next word and the per-cycle SHIFT decisions.
  always_comb begin
    chunk       = chunkBits(32'(remBits));
    inShift     = (state == TXCTRL_SHIFT);
    reloadNow   = inShift && bus.tx_ShiftEmpty && !lastChunk && holdValid && !bus.tx_Abort;
    underrunNow = inShift && bus.tx_ShiftEmpty && !lastChunk && !holdValid;
    finalErase  = inShift && bus.tx_ShiftEmpty && (lastChunk || !holdValid);
    prefetch    = inShift && (remBits != '0) && !holdValid && !bus.TxFifoEmpty && !underrunNow;
  end

  assign bus.TxFifoRd               = fifoRd;
  assign bus.tx_ShiftDataIn         = hold;
  assign bus.tx_ShiftBitCnt         = holdCnt;
  // The seamless reload has to coincide with the cycle the last bit leaves,
  // so it bypasses the load register; the first load of a frame is registered.
  assign bus.tx_ShiftLoad           = loadReg | reloadNow;
  assign bus.tx_ShiftStart          = shiftStart;
  assign bus.tx_FinalShiftLoadErase = finalErase;
  assign bus.tx_Busy                = busy;
  assign bus.tx_FrameDone           = frameDone;
  assign bus.tx_Underrun            = underrun;

  // Frame sequencer with prefetch register and registered strobes.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= TXCTRL_IDLE;
      remBits    <= '0;
      hold       <= '0;
      holdCnt    <= '0;
      holdValid  <= 1'b0;
      lastChunk  <= 1'b0;
      fifoRd     <= 1'b0;
      loadReg    <= 1'b0;
      shiftStart <= 1'b0;
      busy       <= 1'b0;
      frameDone  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      fifoRd    <= 1'b0;
      loadReg   <= 1'b0;
      frameDone <= 1'b0;
      underrun  <= 1'b0;
      if (bus.tx_Abort) begin
        state      <= TXCTRL_IDLE;
        shiftStart <= 1'b0;
        busy       <= 1'b0;
        holdValid  <= 1'b0;
        lastChunk  <= 1'b0;
        remBits    <= '0;
      end else begin
        unique case (state)
          TXCTRL_IDLE: begin
            if (bus.tx_FrameStart) begin
              if (bus.tx_FrameBitLen != '0) begin
                remBits <= bus.tx_FrameBitLen;
                busy    <= 1'b1;
                state   <= TXCTRL_FETCH;
              end else begin
                frameDone <= 1'b1;
              end
            end
          end
          TXCTRL_FETCH: begin
            if (!bus.TxFifoEmpty) begin
              fifoRd    <= 1'b1;
              hold      <= bus.TxFifoData;
              holdCnt   <= chunk;
              remBits   <= remBits - LEN_W'(chunk);
              holdValid <= 1'b1;
              state     <= TXCTRL_LOAD;
            end
          end
          TXCTRL_LOAD: begin
            loadReg    <= 1'b1;
            holdValid  <= 1'b0;
            lastChunk  <= (remBits == '0);
            shiftStart <= 1'b1;
            state      <= TXCTRL_SHIFT;
          end
          TXCTRL_SHIFT: begin
            if (bus.tx_ShiftEmpty && lastChunk) begin
              state <= TXCTRL_DONE;
            end else if (reloadNow) begin
              holdValid <= 1'b0;
              lastChunk <= (remBits == '0);
            end else if (underrunNow) begin
              underrun   <= 1'b1;
              shiftStart <= 1'b0;
              busy       <= 1'b0;
              state      <= TXCTRL_IDLE;
            end else if (prefetch) begin
              fifoRd    <= 1'b1;
              hold      <= bus.TxFifoData;
              holdCnt   <= chunk;
              remBits   <= remBits - LEN_W'(chunk);
              holdValid <= 1'b1;
            end
          end
          TXCTRL_DONE: begin
            frameDone  <= 1'b1;
            shiftStart <= 1'b0;
            busy       <= 1'b0;
            state      <= TXCTRL_IDLE;
          end
          default: begin
            state      <= TXCTRL_IDLE;
            shiftStart <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_txctrl.sv
// Bench for matrix_txctrl: FIFO and shift-register models plus a bit-level
// scoreboard of the serial stream.
module tb_matrix_txctrl;

  localparam int unsigned LEN_W = 16;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic fifoFlush = 1'b0;

  matrix_txctrl_if #(.LEN_W(LEN_W)) bus();

  matrix_txctrl #(.LEN_W(LEN_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // FIFO model (first-word-fall-through)
  logic [31:0] fifoMem [0:15];
  int unsigned wrPtr = 0;
  int unsigned rdPtr = 0;
  assign bus.TxFifoEmpty = (rdPtr == wrPtr);
  assign bus.TxFifoData  = fifoMem[rdPtr % 16];

  always @(posedge Clk) begin
    if (fifoFlush) rdPtr <= wrPtr;
    else if (bus.TxFifoRd && rdPtr != wrPtr) rdPtr <= rdPtr + 1;
  end

  // Shift register model: load wins over shift, idles clear the count.
  logic [31:0] srData;
  logic [7:0]  srCnt;
  assign bus.tx_ShiftEmpty = bus.tx_ShiftStart && (srCnt == 8'd1);

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      srData <= '0;
      srCnt  <= '0;
    end else if (bus.tx_ShiftLoad) begin
      srData <= bus.tx_ShiftDataIn;
      srCnt  <= bus.tx_ShiftBitCnt;
    end else if (!bus.tx_ShiftStart) begin
      srCnt <= '0;
    end else if (srCnt != 0) begin
      srData <= srData << 1;
      srCnt  <= srCnt - 8'd1;
    end
  end

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor, sampled on the falling edge.
  logic        obsBits [$];
  int unsigned obsCyc  [$];
  logic [7:0]  obsCnt  [$];
  int nPops = 0, nLoads = 0, nErase = 0, nEraseOnLast = 0, nDone = 0, nUnder = 0;
  int unsigned lastEraseCyc = 0, lastDoneCyc = 0, lastUnderCyc = 0;

  always @(negedge Clk) begin
    if (Reset) begin
      if (bus.tx_ShiftStart && srCnt != 0) begin
        obsBits.push_back(srData[31]);
        obsCyc.push_back(cyc);
      end
      if (bus.TxFifoRd) nPops++;
      if (bus.tx_ShiftLoad) begin
        nLoads++;
        obsCnt.push_back(bus.tx_ShiftBitCnt);
      end
      if (bus.tx_FinalShiftLoadErase) begin
        nErase++;
        lastEraseCyc = cyc;
        if (bus.tx_ShiftStart && srCnt == 8'd1) nEraseOnLast++;
      end
      if (bus.tx_FrameDone) begin nDone++; lastDoneCyc = cyc; end
      if (bus.tx_Underrun) begin nUnder++; lastUnderCyc = cyc; end
    end
  end

  // Scoreboard state
  logic       expBits [$];
  logic [7:0] expCnt  [$];
  int bitBase = 0, cntBase = 0;
  int bPops, bLoads, bErase, bEraseOnLast, bDone, bUnder;

  task automatic mark();
    bPops = nPops; bLoads = nLoads; bErase = nErase;
    bEraseOnLast = nEraseOnLast; bDone = nDone; bUnder = nUnder;
  endtask

  task automatic pushWord(input logic [31:0] w, input int bits);
    fifoMem[wrPtr % 16] = w;
    wrPtr++;
    for (int i = 0; i < bits; i++) expBits.push_back(w[31-i]);
    expCnt.push_back(8'(bits));
  endtask

  task automatic startFrame(input int len);
    @(negedge Clk);
    bus.tx_FrameStart  = 1'b1;
    bus.tx_FrameBitLen = LEN_W'(len);
    @(negedge Clk);
    bus.tx_FrameStart  = 1'b0;
  endtask

  task automatic waitEnd(input int maxCyc, output bit timedOut);
    int start;
    start = nDone + nUnder;
    timedOut = 1'b1;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge Clk);
      if (nDone + nUnder != start) begin timedOut = 1'b0; break; end
    end
    @(negedge Clk);
  endtask

  task automatic waitBits(input int count, input int maxCyc, output bit timedOut);
    timedOut = 1'b1;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge Clk);
      if (obsBits.size() - bitBase >= count) begin timedOut = 1'b0; break; end
    end
  endtask

  // Pops the scoreboard for every newly observed bit and load; returns tallies.
  task automatic drain(output int nBits, output int badBits, output int gaps, output int badCnt);
    logic e;
    nBits = 0; badBits = 0; gaps = 0; badCnt = 0;
    for (int i = bitBase; i < obsBits.size(); i++) begin
      if (expBits.size() == 0) badBits++;
      else begin
        e = expBits.pop_front();
        if (obsBits[i] !== e) badBits++;
      end
      if (i > bitBase && obsCyc[i] != obsCyc[i-1] + 1) gaps++;
      nBits++;
    end
    bitBase = obsBits.size();
    for (int i = cntBase; i < obsCnt.size(); i++) begin
      if (expCnt.size() == 0) badCnt++;
      else if (obsCnt[i] !== expCnt.pop_front()) badCnt++;
    end
    cntBase = obsCnt.size();
  endtask

  task automatic discardPending();
    expBits.delete();
    expCnt.delete();
    bitBase = obsBits.size();
    cntBase = obsCnt.size();
    @(negedge Clk); fifoFlush = 1'b1;
    @(negedge Clk); fifoFlush = 1'b0;
  endtask

  function automatic logic [46:0] outVec();
    return {bus.TxFifoRd, bus.tx_ShiftLoad, bus.tx_ShiftStart, bus.tx_FinalShiftLoadErase,
            bus.tx_Busy, bus.tx_FrameDone, bus.tx_Underrun, bus.tx_ShiftDataIn, bus.tx_ShiftBitCnt};
  endfunction

  task automatic test_reset();
    @(negedge Clk);
    checks++;
    if (outVec() !== '0) begin failures++; $display("FAIL reset_outputs: actual=%h required=0", outVec()); end
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if ({bus.tx_Busy, bus.tx_ShiftStart, bus.TxFifoRd} !== 3'b000) begin
      failures++; $display("FAIL idle_after_reset: actual=%b required=000", {bus.tx_Busy, bus.tx_ShiftStart, bus.TxFifoRd});
    end
  endtask

  task automatic test_two_words();
    bit to; int n, bad, gaps, badCnt;
    mark();
    pushWord(32'hA5A5A5A5, 32);
    pushWord(32'h0F0F0F0F, 32);
    startFrame(64);
    waitEnd(300, to);
    drain(n, bad, gaps, badCnt);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL w64_timeout: actual=%0d required=0", to); end
    checks++; if (n != 64) begin failures++; $display("FAIL w64_bits: actual=%0d required=64", n); end
    checks++; if (bad != 0) begin failures++; $display("FAIL w64_data: actual=%0d bad bits required=0", bad); end
    checks++; if (gaps != 0) begin failures++; $display("FAIL w64_gap: actual=%0d required=0", gaps); end
    checks++; if (badCnt != 0) begin failures++; $display("FAIL w64_bitcnt: actual=%0d bad required=0", badCnt); end
    checks++; if (nPops - bPops != 2) begin failures++; $display("FAIL w64_pops: actual=%0d required=2", nPops - bPops); end
    checks++; if (nLoads - bLoads != 2) begin failures++; $display("FAIL w64_loads: actual=%0d required=2", nLoads - bLoads); end
    checks++; if (nEraseOnLast - bEraseOnLast != 1 || nErase - bErase != 1) begin
      failures++; $display("FAIL w64_erase: actual=%0d/%0d required=1/1", nErase - bErase, nEraseOnLast - bEraseOnLast); end
    checks++; if (nDone - bDone != 1) begin failures++; $display("FAIL w64_done: actual=%0d required=1", nDone - bDone); end
    checks++; if (lastDoneCyc != lastEraseCyc + 2) begin
      failures++; $display("FAIL w64_done_lat: actual=%0d required=2", lastDoneCyc - lastEraseCyc); end
    checks++; if (nUnder - bUnder != 0) begin failures++; $display("FAIL w64_underrun: actual=%0d required=0", nUnder - bUnder); end
  endtask

  task automatic test_partial_word();
    bit to; int n, bad, gaps, badCnt;
    mark();
    pushWord(32'hFFFFFFFF, 32);
    pushWord(32'h80000000, 8);
    startFrame(40);
    waitEnd(300, to);
    drain(n, bad, gaps, badCnt);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL w40_timeout: actual=%0d required=0", to); end
    checks++; if (n != 40) begin failures++; $display("FAIL w40_bits: actual=%0d required=40", n); end
    checks++; if (bad != 0 || gaps != 0) begin failures++; $display("FAIL w40_data: actual=%0d/%0d required=0/0", bad, gaps); end
    checks++; if (badCnt != 0) begin failures++; $display("FAIL w40_bitcnt: actual=%0d bad required=0", badCnt); end
    checks++; if (nPops - bPops != 2) begin failures++; $display("FAIL w40_pops: actual=%0d required=2", nPops - bPops); end
    checks++; if (nDone - bDone != 1) begin failures++; $display("FAIL w40_done: actual=%0d required=1", nDone - bDone); end
  endtask

  task automatic test_zero_len();
    mark();
    @(negedge Clk);
    bus.tx_FrameStart = 1'b1; bus.tx_FrameBitLen = '0;
    @(negedge Clk);
    bus.tx_FrameStart = 1'b0;
    checks++; if ({bus.tx_FrameDone, bus.tx_Busy} !== 2'b10) begin
      failures++; $display("FAIL zero_done: actual=%b required=10", {bus.tx_FrameDone, bus.tx_Busy}); end
    @(negedge Clk);
    checks++; if (bus.tx_FrameDone !== 1'b0) begin failures++; $display("FAIL zero_pulse: actual=%b required=0", bus.tx_FrameDone); end
    checks++; if (nPops - bPops != 0 || nLoads - bLoads != 0) begin
      failures++; $display("FAIL zero_activity: actual=%0d/%0d required=0/0", nPops - bPops, nLoads - bLoads); end
  endtask

  task automatic test_underrun();
    bit to; int n, bad, gaps, badCnt;
    mark();
    pushWord(32'h3C5A0FF1, 32);
    startFrame(96);
    waitEnd(300, to);
    drain(n, bad, gaps, badCnt);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL ur_timeout: actual=%0d required=0", to); end
    checks++; if (nUnder - bUnder != 1 || nDone - bDone != 0) begin
      failures++; $display("FAIL ur_pulses: actual=%0d/%0d required=1/0", nUnder - bUnder, nDone - bDone); end
    checks++; if (lastUnderCyc != lastEraseCyc + 1 || nEraseOnLast - bEraseOnLast != 1) begin
      failures++; $display("FAIL ur_erase: actual=%0d/%0d required=1/1", lastUnderCyc - lastEraseCyc, nEraseOnLast - bEraseOnLast); end
    checks++; if (n != 32 || bad != 0) begin failures++; $display("FAIL ur_bits: actual=%0d/%0d required=32/0", n, bad); end
    checks++; if ({bus.tx_ShiftStart, bus.tx_Busy} !== 2'b00) begin
      failures++; $display("FAIL ur_idle: actual=%b required=00", {bus.tx_ShiftStart, bus.tx_Busy}); end
    checks++; if (nPops - bPops != 1) begin failures++; $display("FAIL ur_pops: actual=%0d required=1", nPops - bPops); end
    discardPending();
  endtask

  task automatic test_abort();
    bit to; int n, bad, gaps, badCnt;
    mark();
    pushWord(32'hDEADBEEF, 32);
    pushWord(32'h01234567, 32);
    startFrame(64);
    waitBits(10, 100, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL ab_start_timeout: actual=%0d required=0", to); end
    bus.tx_Abort = 1'b1;
    @(negedge Clk);
    checks++; if ({bus.tx_ShiftStart, bus.tx_Busy, bus.tx_ShiftLoad, bus.TxFifoRd} !== 4'b0000) begin
      failures++; $display("FAIL ab_stop: actual=%b required=0000",
                           {bus.tx_ShiftStart, bus.tx_Busy, bus.tx_ShiftLoad, bus.TxFifoRd}); end
    bus.tx_Abort = 1'b0;
    repeat (5) @(negedge Clk);
    drain(n, bad, gaps, badCnt);
    checks++; if (nDone - bDone != 0 || nUnder - bUnder != 0) begin
      failures++; $display("FAIL ab_pulses: actual=%0d/%0d required=0/0", nDone - bDone, nUnder - bUnder); end
    checks++; if (bad != 0) begin failures++; $display("FAIL ab_prefix: actual=%0d bad required=0", bad); end
    discardPending();
    mark();
    pushWord(32'h12345678, 32);
    startFrame(32);
    waitEnd(200, to);
    drain(n, bad, gaps, badCnt);
    checks++; if (to !== 1'b0 || nDone - bDone != 1) begin
      failures++; $display("FAIL ab_restart_done: actual=%0d required=1", nDone - bDone); end
    checks++; if (n != 32 || bad != 0 || badCnt != 0) begin
      failures++; $display("FAIL ab_restart_bits: actual=%0d/%0d/%0d required=32/0/0", n, bad, badCnt); end
  endtask

  task automatic test_ignore_and_reset();
    bit to; int n, bad, gaps, badCnt;
    mark();
    pushWord(32'hC0FFEE11, 32);
    pushWord(32'h5555AAAA, 32);
    startFrame(64);
    waitBits(5, 100, to);
    bus.tx_FrameStart = 1'b1; bus.tx_FrameBitLen = LEN_W'(8);
    @(negedge Clk);
    bus.tx_FrameStart = 1'b0;
    waitEnd(300, to);
    drain(n, bad, gaps, badCnt);
    checks++; if (to !== 1'b0 || nDone - bDone != 1) begin
      failures++; $display("FAIL ign_done: actual=%0d required=1", nDone - bDone); end
    checks++; if (n != 64 || bad != 0 || gaps != 0) begin
      failures++; $display("FAIL ign_bits: actual=%0d/%0d/%0d required=64/0/0", n, bad, gaps); end
    checks++; if (nPops - bPops != 2 || nLoads - bLoads != 2) begin
      failures++; $display("FAIL ign_pops_loads: actual=%0d/%0d required=2/2", nPops - bPops, nLoads - bLoads); end
    // Reset in the middle of SHIFT.
    pushWord(32'h77777777, 32);
    startFrame(32);
    waitBits(3, 100, to);
    #2 Reset = 1'b0;
    #1;
    checks++; if (outVec() !== '0) begin failures++; $display("FAIL rst_mid_shift: actual=%h required=0", outVec()); end
    @(negedge Clk);
    Reset = 1'b1;
    discardPending();
    // Partial single word after reset.
    mark();
    pushWord(32'hC3C30001, 20);
    startFrame(20);
    waitEnd(200, to);
    drain(n, bad, gaps, badCnt);
    checks++; if (to !== 1'b0 || nDone - bDone != 1) begin
      failures++; $display("FAIL post_rst_done: actual=%0d required=1", nDone - bDone); end
    checks++; if (n != 20 || bad != 0 || badCnt != 0) begin
      failures++; $display("FAIL post_rst_bits: actual=%0d/%0d/%0d required=20/0/0", n, bad, badCnt); end
  endtask

  initial begin
    bus.tx_FrameStart  = 1'b0;
    bus.tx_FrameBitLen = '0;
    bus.tx_Abort       = 1'b0;
    test_reset();
    test_two_words();
    test_partial_word();
    test_zero_len();
    test_underrun();
    test_abort();
    test_ignore_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=expired required=finished");
    $fatal(1);
  end

endmodule
